// File: rtl/syn_lb_router_pkg.sv
// Shared types and constants for the local-bus router.
package syn_lb_router_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int unsigned ERR_CNT_W    = 16;
    localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_DEAD;

    // Adds up to two error events in one cycle; sticks at all-ones.
    function automatic logic [ERR_CNT_W-1:0] err_sat_add(
        input logic [ERR_CNT_W-1:0] cnt,
        input logic [1:0]           inc
    );
        logic [ERR_CNT_W:0] sum;
        sum = {1'b0, cnt} + {{(ERR_CNT_W-1){1'b0}}, inc};
        return sum[ERR_CNT_W] ? '1 : sum[ERR_CNT_W-1:0];
    endfunction

endpackage

// File: rtl/syn_lb_timeout_cntr.sv
// Wait-cycle counter for the router; only built with SYN_LB_ROUTER_TIMEOUT_EN.
module syn_lb_timeout_cntr #(
    parameter int unsigned P_TIMEOUT = 255
) (
    input  logic clk_ir,
    input  logic rst_sync_l,
    input  logic load,
    input  logic run,
    output logic expire
);

    localparam int unsigned CW = (P_TIMEOUT < 1) ? 1 : $clog2(P_TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(P_TIMEOUT);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk_ir or negedge rst_sync_l) begin
        if (!rst_sync_l) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (run && cnt != LIMIT) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expire = (cnt == LIMIT);

endmodule

// File: rtl/syn_lb_router.sv
// Single-outstanding local-bus router: block-select decode, one-hot slave strobes,
// error completion for unmapped blocks. Optional slave timeout: SYN_LB_ROUTER_TIMEOUT_EN.
module syn_lb_router
    import syn_lb_router_pkg::*;
#(
    parameter int unsigned           P_NUM_SLAVES = 2,
    parameter int unsigned           P_DATA_W     = 32,
    parameter int unsigned           P_ADDR_W     = 16,
    parameter int unsigned           P_BLK_AW     = 4,
    parameter int unsigned           P_TIMEOUT    = 255,
    parameter logic [P_DATA_W-1:0]   P_ERR_DATA   = P_DATA_W'(ERR_DATA_DEF)
) (
    input  logic                             clk_ir,
    input  logic                             rst_sync_l,
    input  logic                             mst_rd_en,
    input  logic                             mst_wr_en,
    input  logic [P_ADDR_W-1:0]              mst_addr,
    input  logic [P_DATA_W-1:0]              mst_wr_data,
    output logic                             mst_rd_valid,
    output logic                             mst_wr_valid,
    output logic [P_DATA_W-1:0]              mst_rd_data,
    output logic [P_NUM_SLAVES-1:0]          slv_rd_en,
    output logic [P_NUM_SLAVES-1:0]          slv_wr_en,
    output logic [P_ADDR_W-P_BLK_AW-1:0]     slv_addr,
    output logic [P_DATA_W-1:0]              slv_wr_data,
    input  logic [P_NUM_SLAVES-1:0]          slv_rd_valid,
    input  logic [P_NUM_SLAVES-1:0]          slv_wr_valid,
    input  logic [P_NUM_SLAVES*P_DATA_W-1:0] slv_rd_data,
    output logic                             busy,
    output logic [ERR_CNT_W-1:0]             err_cnt
);

    localparam int unsigned SLV_AW = P_ADDR_W - P_BLK_AW;

    if (P_NUM_SLAVES < 1 || P_NUM_SLAVES > 16 || P_BLK_AW >= P_ADDR_W || P_TIMEOUT < 1) begin : g_param_chk
        $error("syn_lb_router: illegal parameter combination");
    end

    state_t                  state;
    logic                    is_wr;
    logic [P_NUM_SLAVES-1:0] sel_oh_q;
    logic [P_NUM_SLAVES-1:0] sel_oh_d;
    logic [P_BLK_AW-1:0]     sel;
    logic                    req;
    logic                    mapped;
    logic                    accept;
    logic                    drop;
    logic                    hit;
    logic                    timeout;
    logic [P_DATA_W-1:0]     rd_slice;
    logic [1:0]              err_inc;

    assign req    = mst_rd_en | mst_wr_en;
    assign sel    = mst_addr[P_ADDR_W-1 -: P_BLK_AW];
    assign mapped = 32'(sel) < P_NUM_SLAVES;
    assign accept = req && (state == ST_IDLE);
    assign drop   = req && (state != ST_IDLE);
    assign busy   = (state != ST_IDLE);

    always_comb begin
        sel_oh_d = '0;
        for (int unsigned i = 0; i < P_NUM_SLAVES; i++) begin
            sel_oh_d[i] = (32'(sel) == i);
        end
    end

    // Selection is held one-hot so the data mux is a plain AND-OR.
    always_comb begin
        rd_slice = '0;
        for (int unsigned i = 0; i < P_NUM_SLAVES; i++) begin
            if (sel_oh_q[i]) begin
                rd_slice = rd_slice | slv_rd_data[i*P_DATA_W +: P_DATA_W];
            end
        end
    end

    assign hit = (state == ST_WAIT) &&
                 (is_wr ? |(slv_wr_valid & sel_oh_q) : |(slv_rd_valid & sel_oh_q));

`ifdef SYN_LB_ROUTER_TIMEOUT_EN
    logic expire;

    syn_lb_timeout_cntr #(
        .P_TIMEOUT (P_TIMEOUT)
    ) u_timeout_cntr (
        .clk_ir     (clk_ir),
        .rst_sync_l (rst_sync_l),
        .load       (accept),
        .run        (state == ST_WAIT),
        .expire     (expire)
    );

    assign timeout = (state == ST_WAIT) && expire && !hit;
`else
    assign timeout = 1'b0;
`endif

    assign err_inc = 2'(drop) + 2'(accept && !mapped) + 2'(timeout);

    always_ff @(posedge clk_ir or negedge rst_sync_l) begin
        if (!rst_sync_l) begin
            state        <= ST_IDLE;
            is_wr        <= 1'b0;
            sel_oh_q     <= '0;
            slv_rd_en    <= '0;
            slv_wr_en    <= '0;
            slv_addr     <= '0;
            slv_wr_data  <= '0;
            mst_rd_valid <= 1'b0;
            mst_wr_valid <= 1'b0;
            mst_rd_data  <= '0;
            err_cnt      <= '0;
        end else begin
            slv_rd_en    <= '0;
            slv_wr_en    <= '0;
            mst_rd_valid <= 1'b0;
            mst_wr_valid <= 1'b0;
            err_cnt      <= err_sat_add(err_cnt, err_inc);
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        is_wr       <= mst_wr_en;
                        slv_addr    <= mst_addr[SLV_AW-1:0];
                        slv_wr_data <= mst_wr_data;
                        if (mapped) begin
                            sel_oh_q  <= sel_oh_d;
                            slv_wr_en <= mst_wr_en ? sel_oh_d : '0;
                            slv_rd_en <= mst_wr_en ? '0 : sel_oh_d;
                            state     <= ST_WAIT;
                        end else begin
                            sel_oh_q     <= '0;
                            mst_wr_valid <= mst_wr_en;
                            mst_rd_valid <= !mst_wr_en;
                            if (!mst_wr_en) begin
                                mst_rd_data <= P_ERR_DATA;
                            end
                            state <= ST_RESP;
                        end
                    end
                end
                ST_WAIT: begin
                    if (hit || timeout) begin
                        mst_wr_valid <= is_wr;
                        mst_rd_valid <= !is_wr;
                        if (!is_wr) begin
                            mst_rd_data <= hit ? rd_slice : P_ERR_DATA;
                        end
                        state <= ST_RESP;
                    end
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_syn_lb_router.sv
// Bench for syn_lb_router: directed scenarios plus random traffic against a timestamp-based model.
`timescale 1ns/1ps
module tb_syn_lb_router;

    localparam int unsigned N   = 2;
    localparam int unsigned DW  = 32;
    localparam int unsigned AW  = 16;
    localparam int unsigned BAW = 4;
    localparam int unsigned SAW = AW - BAW;
    localparam logic [31:0] ERRD = 32'hDEAD_DEAD;
`ifdef SYN_LB_ROUTER_TIMEOUT_EN
    localparam int unsigned TMO = 8;
`endif

    logic            clk_ir = 1'b0;
    logic            rst_sync_l;
    logic            mst_rd_en, mst_wr_en;
    logic [AW-1:0]   mst_addr;
    logic [DW-1:0]   mst_wr_data;
    logic            mst_rd_valid, mst_wr_valid;
    logic [DW-1:0]   mst_rd_data;
    logic [N-1:0]    slv_rd_en, slv_wr_en;
    logic [SAW-1:0]  slv_addr;
    logic [DW-1:0]   slv_wr_data;
    logic [N-1:0]    slv_rd_valid, slv_wr_valid;
    logic [N*DW-1:0] slv_rd_data;
    logic            busy;
    logic [15:0]     err_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk_ir = ~clk_ir;

    syn_lb_router #(
        .P_NUM_SLAVES (N),
        .P_DATA_W     (DW),
        .P_ADDR_W     (AW),
        .P_BLK_AW     (BAW)
`ifdef SYN_LB_ROUTER_TIMEOUT_EN
        , .P_TIMEOUT  (TMO)
`endif
    ) dut (
        .clk_ir       (clk_ir),
        .rst_sync_l   (rst_sync_l),
        .mst_rd_en    (mst_rd_en),
        .mst_wr_en    (mst_wr_en),
        .mst_addr     (mst_addr),
        .mst_wr_data  (mst_wr_data),
        .mst_rd_valid (mst_rd_valid),
        .mst_wr_valid (mst_wr_valid),
        .mst_rd_data  (mst_rd_data),
        .slv_rd_en    (slv_rd_en),
        .slv_wr_en    (slv_wr_en),
        .slv_addr     (slv_addr),
        .slv_wr_data  (slv_wr_data),
        .slv_rd_valid (slv_rd_valid),
        .slv_wr_valid (slv_wr_valid),
        .slv_rd_data  (slv_rd_data),
        .busy         (busy),
        .err_cnt      (err_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: one transaction record with acceptance/response timestamps.
    longint       cyc = 0;
    longint       p;
    longint       m_tacc = 0;
    longint       m_resp = 0;
    bit           m_active = 0, m_known = 0, m_wr = 0, m_mapped = 0, busy_p;
    int           m_sel = 0;
    logic [3:0]   blk;
    logic [N-1:0] exp_slv_rd_en = '0, exp_slv_wr_en = '0;
    logic         exp_rd_valid = 0, exp_wr_valid = 0, exp_busy = 0;
    logic [DW-1:0] exp_rd_data = '0, exp_wr_data = '0;
    logic [SAW-1:0] exp_addr = '0;
    logic [15:0]  exp_err = '0;

    task automatic inc_err();
        if (exp_err != 16'hFFFF) exp_err = exp_err + 16'd1;
    endtask

    task automatic complete(input logic [DW-1:0] d);
        m_known = 1;
        m_resp  = p + 1;
        if (m_wr) exp_wr_valid = 1;
        else begin
            exp_rd_valid = 1;
            exp_rd_data  = d;
        end
    endtask

    always @(posedge clk_ir or negedge rst_sync_l) begin
        if (!rst_sync_l) begin
            m_active = 0; m_known = 0; m_mapped = 0;
            exp_slv_rd_en = '0; exp_slv_wr_en = '0;
            exp_rd_valid = 0; exp_wr_valid = 0; exp_busy = 0;
            exp_rd_data = '0; exp_wr_data = '0; exp_addr = '0; exp_err = '0;
        end else begin
            p = cyc;
            cyc = cyc + 1;
            exp_slv_rd_en = '0; exp_slv_wr_en = '0;
            exp_rd_valid = 0; exp_wr_valid = 0;
            busy_p = m_active;
            if (m_active && m_known && m_resp == p) m_active = 0;
            if (m_active && !m_known && p > m_tacc) begin
                if (m_wr ? slv_wr_valid[m_sel] : slv_rd_valid[m_sel])
                    complete(slv_rd_data[m_sel*DW +: DW]);
`ifdef SYN_LB_ROUTER_TIMEOUT_EN
                else if (p - m_tacc == longint'(TMO) + 1) begin
                    inc_err();
                    complete(ERRD);
                end
`endif
            end
            if (mst_rd_en || mst_wr_en) begin
                if (busy_p) inc_err();
                else begin
                    blk         = mst_addr[AW-1 -: BAW];
                    m_sel       = int'(blk);
                    m_wr        = mst_wr_en;
                    m_tacc      = p;
                    m_active    = 1;
                    m_mapped    = (m_sel < int'(N));
                    exp_addr    = mst_addr[SAW-1:0];
                    exp_wr_data = mst_wr_data;
                    if (m_mapped) begin
                        m_known = 0;
                        if (m_wr) exp_slv_wr_en[m_sel] = 1'b1;
                        else      exp_slv_rd_en[m_sel] = 1'b1;
                    end else begin
                        inc_err();
                        complete(ERRD);
                    end
                end
            end
            exp_busy = m_active;
        end
    end

    always @(posedge clk_ir) begin
        #2;
        chk("busy", 64'(busy), 64'(exp_busy));
        chk("slv_rd_en", 64'(slv_rd_en), 64'(exp_slv_rd_en));
        chk("slv_wr_en", 64'(slv_wr_en), 64'(exp_slv_wr_en));
        chk("mst_rd_valid", 64'(mst_rd_valid), 64'(exp_rd_valid));
        chk("mst_wr_valid", 64'(mst_wr_valid), 64'(exp_wr_valid));
        chk("mst_rd_data", 64'(mst_rd_data), 64'(exp_rd_data));
        chk("err_cnt", 64'(err_cnt), 64'(exp_err));
        if (exp_busy && m_mapped) begin
            chk("slv_addr", 64'(slv_addr), 64'(exp_addr));
            chk("slv_wr_data", 64'(slv_wr_data), 64'(exp_wr_data));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_ir);
    endtask

    task automatic clr();
        mst_rd_en = 0; mst_wr_en = 0;
        slv_rd_valid = '0; slv_wr_valid = '0;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_sync_l = 0;
        clr();
        mst_addr = '0; mst_wr_data = '0; slv_rd_data = '0;
        tick(3);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset err_cnt", 64'(err_cnt), 64'd0);
        chk("reset rd_data", 64'(mst_rd_data), 64'd0);
        rst_sync_l = 1;
        tick(2);

        // Read slave 1, response three cycles after strobe
        mst_rd_en = 1; mst_addr = 16'h1004;
        tick(1); clr();
        chk("r1 strobe", 64'(slv_rd_en), 64'h2);
        chk("r1 slv_addr", 64'(slv_addr), 64'h004);
        tick(3);
        slv_rd_valid = 2'b10; slv_rd_data = {32'h1234_5678, 32'h0};
        tick(1); clr();
        chk("r1 valid", 64'(mst_rd_valid), 64'd1);
        chk("r1 data", 64'(mst_rd_data), 64'h1234_5678);
        tick(2);

        // Write slave 0
        mst_wr_en = 1; mst_addr = 16'h0010; mst_wr_data = 32'hA5A5_A5A5;
        tick(1); clr();
        chk("w0 strobe", 64'(slv_wr_en), 64'h1);
        chk("w0 wdata", 64'(slv_wr_data), 64'hA5A5_A5A5);
        tick(1);
        slv_wr_valid = 2'b01;
        tick(1); clr();
        chk("w0 valid", 64'(mst_wr_valid), 64'd1);
        chk("w0 err", 64'(err_cnt), 64'd0);
        chk("w0 rd_data kept", 64'(mst_rd_data), 64'h1234_5678);
        tick(2);

        // Unmapped block
        mst_rd_en = 1; mst_addr = 16'hF000;
        tick(1); clr();
        chk("um strobe", 64'({slv_rd_en, slv_wr_en}), 64'd0);
        chk("um valid", 64'(mst_rd_valid), 64'd1);
        chk("um data", 64'(mst_rd_data), 64'hDEAD_DEAD);
        chk("um err", 64'(err_cnt), 64'd1);
        tick(2);

        // Busy drop, stray valid from unselected slave and wrong direction
        mst_rd_en = 1; mst_addr = 16'h1008;
        tick(1); clr();
        tick(1);
        mst_wr_en = 1; mst_addr = 16'h0000; mst_wr_data = 32'h1;
        slv_rd_valid = 2'b01; slv_rd_data = {32'h0, 32'h1111_1111};
        tick(1); clr();
        slv_wr_valid = 2'b10;
        chk("bd no valid", 64'(mst_rd_valid), 64'd0);
        chk("bd err", 64'(err_cnt), 64'd2);
        tick(1); clr();
        chk("bd wrong dir", 64'({mst_rd_valid, mst_wr_valid}), 64'd0);
        slv_rd_valid = 2'b10; slv_rd_data = {32'hCAFE_F00D, 32'h2222_2222};
        tick(1); clr();
        chk("bd valid", 64'(mst_rd_valid), 64'd1);
        chk("bd data", 64'(mst_rd_data), 64'hCAFE_F00D);
        tick(2);

        // Reset while waiting, then a late slave valid
        mst_rd_en = 1; mst_addr = 16'h0020;
        tick(1); clr();
        tick(1);
        rst_sync_l = 0;
        #1;
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst rd_data", 64'(mst_rd_data), 64'd0);
        chk("rst err", 64'(err_cnt), 64'd0);
        tick(1);
        rst_sync_l = 1;
        tick(1);
        slv_rd_valid = 2'b01;
        tick(1); clr();
        chk("late valid", 64'(mst_rd_valid), 64'd0);
        chk("late busy", 64'(busy), 64'd0);
        tick(2);

`ifdef SYN_LB_ROUTER_TIMEOUT_EN
        // Silent slave times out; valid in the expiry cycle still succeeds
        mst_rd_en = 1; mst_addr = 16'h0040;
        tick(1); clr();
        tick(7);
        chk("to early", 64'(mst_rd_valid), 64'd0);
        tick(1);
        chk("to valid", 64'(mst_rd_valid), 64'd1);
        chk("to data", 64'(mst_rd_data), 64'hDEAD_DEAD);
        chk("to err", 64'(err_cnt), 64'd1);
        tick(2);
        mst_rd_en = 1; mst_addr = 16'h0044;
        tick(1); clr();
        tick(7);
        slv_rd_valid = 2'b01; slv_rd_data = {32'h0, 32'h0BAD_BEEF};
        tick(1); clr();
        chk("edge valid", 64'(mst_rd_valid), 64'd1);
        chk("edge data", 64'(mst_rd_data), 64'h0BAD_BEEF);
        chk("edge err", 64'(err_cnt), 64'd1);
        tick(2);
`endif

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            clr();
            if ($urandom_range(0, 3) == 0) begin
                mst_rd_en = 1'($urandom);
                mst_wr_en = 1'($urandom);
                if (!mst_rd_en && !mst_wr_en) mst_rd_en = 1;
                mst_addr = {4'($urandom_range(0, 3)), 12'($urandom)};
                mst_wr_data = $urandom;
            end
            for (int s = 0; s < int'(N); s++) begin
                slv_rd_valid[s] = ($urandom_range(0, 4) == 0);
                slv_wr_valid[s] = ($urandom_range(0, 4) == 0);
            end
            slv_rd_data = {$urandom, $urandom};
            tick(1);
        end
        clr();
        tick(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
